// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB camera-side responder with 2^ADDR_W x 8 register file
// Ports:
//   XCLK, RST          system clock, asynchronous active-high reset
//   SIO_C, SIO_D       SCCB bus from the master; SIO_D is open drain (0 or 'z')
//   wr_pulse/addr/data one-cycle strobe with address and byte of each committed write
//   dbg_addr/dbg_data  combinational debug read port into the register file
//   busy               high from START detect until STOP detect
module sccb_slave #(
  parameter logic [6:0] DEV_ID      = 7'h21,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              XCLK,
  input  logic              RST,
  input  logic              SIO_C,
  inout  wire               SIO_D,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ID, ST_ID_ACK, ST_SUB, ST_SUB_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic              c_prev, d_prev;
  logic              scl, sda;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        shifter;
  logic [3:0]        bit_cnt;
  logic [ADDR_W-1:0] sub_addr, sub_addr_inc;
  logic              sda_oe;
  logic [7:0]        regs [2**ADDR_W];
  logic [7:0]        rd_cur, rd_next;

  // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], SIO_C};
      d_sync <= {d_sync[SYNC_STAGES-2:0], SIO_D};
      c_prev <= c_sync[SYNC_STAGES-1];
      d_prev <= d_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = c_sync[SYNC_STAGES-1];
  assign sda       = d_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~c_prev;
  assign scl_fall  = ~scl & c_prev;
  assign start_det = d_prev & ~sda & scl & c_prev;
  assign stop_det  = ~d_prev & sda & scl & c_prev;

  assign sub_addr_inc = sub_addr + ADDR_W'(1);
  assign rd_cur       = regs[sub_addr];
  assign rd_next      = regs[sub_addr_inc];

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // shifter[0] holds the R/W bit in ID_ACK and the master's ACK bit in RDATA_ACK.
  always_comb begin
    next_state = state;
    if (start_det) begin
      next_state = ST_ID;
    end else if (stop_det) begin
      next_state = ST_IDLE;
    end else if (scl_fall) begin
      case (state)
        ST_ID:        if (bit_cnt == 4'd8)
                        next_state = (shifter[7:1] == DEV_ID) ? ST_ID_ACK : ST_IGNORE;
        ST_ID_ACK:    next_state = shifter[0] ? ST_RDATA : ST_SUB;
        ST_SUB:       if (bit_cnt == 4'd8) next_state = ST_SUB_ACK;
        ST_SUB_ACK:   next_state = ST_WDATA;
        ST_WDATA:     if (bit_cnt == 4'd8) next_state = ST_WDATA_ACK;
        ST_WDATA_ACK: next_state = ST_WDATA;
        ST_RDATA:     if (bit_cnt == 4'd8) next_state = ST_RDATA_ACK;
        ST_RDATA_ACK: next_state = shifter[0] ? ST_IGNORE : ST_RDATA;
        default:      next_state = state;
      endcase
    end
  end

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      shifter  <= '0;
      bit_cnt  <= '0;
      sub_addr <= '0;
      sda_oe   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ID, ST_SUB, ST_WDATA:
            if (bit_cnt != 4'd8) begin
              shifter <= {shifter[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end
          ST_RDATA:
            if (bit_cnt != 4'd8) begin
              shifter <= {shifter[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          ST_RDATA_ACK: shifter <= {shifter[6:0], sda};
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ID:
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= (shifter[7:1] == DEV_ID);
            end
          ST_ID_ACK: begin
            bit_cnt <= '0;
            if (shifter[0]) begin
              // Read: first data bit goes out on the same edge that ends the ACK.
              shifter <= rd_cur;
              sda_oe  <= ~rd_cur[7];
            end else begin
              sda_oe  <= 1'b0;
            end
          end
          ST_SUB:
            if (bit_cnt == 4'd8) begin
              bit_cnt  <= '0;
              sub_addr <= ADDR_W'(shifter);
              sda_oe   <= 1'b1;
            end
          ST_SUB_ACK: sda_oe <= 1'b0;
          ST_WDATA:
            if (bit_cnt == 4'd8) begin
              bit_cnt        <= '0;
              regs[sub_addr] <= shifter;
              wr_pulse       <= 1'b1;
              wr_addr        <= sub_addr;
              wr_data        <= shifter;
              sda_oe         <= 1'b1;
            end
          ST_WDATA_ACK: begin
            sda_oe   <= 1'b0;
            sub_addr <= sub_addr_inc;
          end
          ST_RDATA:
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
            end else begin
              sda_oe  <= ~shifter[7];
            end
          ST_RDATA_ACK:
            if (!shifter[0]) begin
              sub_addr <= sub_addr_inc;
              shifter  <= rd_next;
              sda_oe   <= ~rd_next[7];
            end else begin
              sda_oe   <= 1'b0;
            end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    dbg_data = regs[dbg_addr];
  end

  // RST gates the driver directly so the line is released without waiting for a clock.
  assign SIO_D = (sda_oe && !RST) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - directed bench for sccb_slave acting as an SCCB master
module tb_sccb_slave;
  localparam int H = 8;

  logic       xclk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  wire        sio_d;
  logic       wr_pulse;
  logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];

  always #5 xclk = ~xclk;

  pullup (sio_d);
  assign sio_d = m_sda ? 1'bz : 1'b0;

  sccb_slave dut (
    .XCLK(xclk), .RST(rst), .SIO_C(m_scl), .SIO_D(sio_d),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always @(negedge xclk) begin
    if (wr_pulse) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (m_sda && sio_d === 1'b0) low_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_clk(H);
    m_scl = 1'b1; wait_clk(H);
    m_sda = 1'b0; wait_clk(H);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_clk(H);
    m_scl = 1'b1; wait_clk(H);
    m_sda = 1'b1; wait_clk(H);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b;    wait_clk(H);
    m_scl = 1'b1; wait_clk(H/2);
    r = sio_d;    wait_clk(H/2);
    m_scl = 1'b0; wait_clk(2);
  endtask

  task automatic m_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(input logic nack, output logic [7:0] d, output logic r9);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(nack, r9);
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    dbg_addr = a;
    wait_clk(1);
    d = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; dbg_addr = 8'h00;
    wait_clk(5);
    checks++; if (sio_d !== 1'b1) begin errors++; $display("FAIL reset_sio_d: got %b expected 1", sio_d); end
    rst = 1'b0;
    wait_clk(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
    checks++; if ({wr_addr, wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr_bus: got %h expected 0000", {wr_addr, wr_data}); end
    peek(8'h12, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg12: got %h expected 00", d); end
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    logic [7:0] d;
    int base;
    base = wq_addr.size();
    m_start();
    m_byte(8'h42, a0); m_byte(8'h12, a1); m_byte(8'h80, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b expected 1", busy); end
    m_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    checks++; if (wq_addr.size() !== base + 1) begin errors++; $display("FAIL write_pulse_count: got %0d expected %0d", wq_addr.size() - base, 1); end
    if (wq_addr.size() > base) begin
      checks++; if ({wq_addr[base], wq_data[base]} !== 16'h1280) begin errors++; $display("FAIL write_pulse_payload: got %h expected 1280", {wq_addr[base], wq_data[base]}); end
    end
    peek(8'h12, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL write_dbg_reg12: got %h expected 80", d); end
  endtask

  task automatic test_read();
    logic a, r9;
    logic [7:0] d;
    int base;
    base = wq_addr.size();
    m_start(); m_byte(8'h42, a); m_byte(8'h12, a); m_stop();
    m_start();
    m_byte(8'h43, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_id_ack: got %b expected 0", a); end
    m_read_byte(1'b1, d, r9);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL read_data: got %h expected 80", d); end
    checks++; if (r9 !== 1'b1) begin errors++; $display("FAIL read_release_9th: got %b expected 1", r9); end
    m_stop();
    m_start(); m_byte(8'h43, a); m_read_byte(1'b1, d, r9); m_stop();
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL read_subaddr_kept: got %h expected 80", d); end
    checks++; if (wq_addr.size() !== base) begin errors++; $display("FAIL read_no_write: got %0d pulses expected 0", wq_addr.size() - base); end
  endtask

  task automatic test_bad_id();
    logic a0, a1, a2;
    logic [7:0] d;
    int base, lbase;
    base = wq_addr.size(); lbase = low_cnt;
    m_start();
    m_byte(8'h60, a0); m_byte(8'h12, a1); m_byte(8'h55, a2);
    m_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL badid_acks: got %b expected 111", {a0, a1, a2}); end
    checks++; if (low_cnt !== lbase) begin errors++; $display("FAIL badid_sio_d_low: got %0d low samples expected 0", low_cnt - lbase); end
    checks++; if (wq_addr.size() !== base) begin errors++; $display("FAIL badid_no_write: got %0d pulses expected 0", wq_addr.size() - base); end
    peek(8'h12, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL badid_reg12: got %h expected 80", d); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    int base;
    base = wq_addr.size();
    m_start();
    m_byte(8'h42, a0); m_byte(8'hFF, a1); m_byte(8'hAA, a2); m_byte(8'hBB, a3);
    m_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); end
    checks++; if (wq_addr.size() !== base + 2) begin errors++; $display("FAIL wrap_pulse_count: got %0d expected 2", wq_addr.size() - base); end
    if (wq_addr.size() >= base + 2) begin
      checks++; if ({wq_addr[base], wq_data[base], wq_addr[base+1], wq_data[base+1]} !== 32'hFFAA00BB) begin
        errors++; $display("FAIL wrap_pulse_payload: got %h expected ffaa00bb", {wq_addr[base], wq_data[base], wq_addr[base+1], wq_data[base+1]});
      end
    end
    peek(8'hFF, d);
    checks++; if (d !== 8'hAA) begin errors++; $display("FAIL wrap_regFF: got %h expected aa", d); end
    peek(8'h00, d);
    checks++; if (d !== 8'hBB) begin errors++; $display("FAIL wrap_reg00: got %h expected bb", d); end
  endtask

  task automatic test_partial_restart();
    logic a, r, r9;
    logic [7:0] d;
    int base;
    m_start(); m_byte(8'h42, a); m_byte(8'h05, a); m_byte(8'h3C, a); m_stop();
    base = wq_addr.size();
    m_start(); m_byte(8'h42, a); m_byte(8'h05, a);
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r);
    m_stop();
    checks++; if (wq_addr.size() !== base) begin errors++; $display("FAIL partial_no_write: got %0d pulses expected 0", wq_addr.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_idle: got busy %b expected 0", busy); end
    peek(8'h05, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL partial_reg05: got %h expected 3c", d); end
    m_start(); m_byte(8'h42, a); m_byte(8'h05, a);
    m_start();
    m_byte(8'h43, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL restart_id_ack: got %b expected 0", a); end
    m_read_byte(1'b1, d, r9);
    m_stop();
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL restart_read: got %h expected 3c", d); end
  endtask

  task automatic test_reset_mid();
    logic r, a;
    logic [7:0] d;
    logic [7:0] b;
    int base;
    b = 8'h42;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_sda = 1'b1;
    wait_clk(4);
    checks++; if (sio_d !== 1'b0) begin errors++; $display("FAIL rstmid_ack_driven: got %b expected 0", sio_d); end
    rst = 1'b1;
    #1;
    checks++; if (sio_d !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b expected 1", sio_d); end
    wait_clk(3);
    peek(8'h12, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_reg12: got %h expected 00", d); end
    peek(8'hFF, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_regFF: got %h expected 00", d); end
    peek(8'h05, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_reg05: got %h expected 00", d); end
    rst = 1'b0;
    wait_clk(4);
    m_stop();
    base = wq_addr.size();
    m_start(); m_byte(8'h42, a); m_byte(8'h07, a); m_byte(8'h99, a); m_stop();
    peek(8'h07, d);
    checks++; if (d !== 8'h99 || wq_addr.size() !== base + 1) begin
      errors++; $display("FAIL rstmid_recover: got reg07 %h pulses %0d expected 99 and 1", d, wq_addr.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_id();
    test_wrap();
    test_partial_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
